// File: rtl/main_ctrl_pkg.sv
// main_ctrl_pkg
//   Shared definitions for the multi-cycle main control unit and ALU_Control:
//   state encodings, supported RISC-V opcodes and the 2-bit ALU operation
//   class. No ports.
package main_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_EXEC_R   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_HALT     = 4'd10
  } state_t;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALU operation class handed to ALU_Control.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // States that stall on the memory handshake.
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// main_control_fsm_if
//   Control bundle between the main control FSM and the datapath/memory.
//   Inputs to the FSM: start, opcode[6:0], mem_ready.
//   Outputs from the FSM: ALU_OpOut[1:0], ALUSrcA, ALUSrcB[1:0], IorD,
//   MemRead, MemWrite, IR_Write, PC_Write, PC_WriteCond, PCSource,
//   RegWrite, MemtoReg, busy, illegal, mem_err.
//   master = the control FSM, slave = datapath / environment.
interface main_control_fsm_if;
  logic       start;
  logic [6:0] opcode;
  logic       mem_ready;

  logic [1:0] ALU_OpOut;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IR_Write;
  logic       PC_Write;
  logic       PC_WriteCond;
  logic       PCSource;
  logic       RegWrite;
  logic       MemtoReg;
  logic       busy;
  logic       illegal;
  logic       mem_err;

  modport master (
    input  start, opcode, mem_ready,
    output ALU_OpOut, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite,
           IR_Write, PC_Write, PC_WriteCond, PCSource, RegWrite, MemtoReg,
           busy, illegal, mem_err
  );

  modport slave (
    output start, opcode, mem_ready,
    input  ALU_OpOut, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite,
           IR_Write, PC_Write, PC_WriteCond, PCSource, RegWrite, MemtoReg,
           busy, illegal, mem_err
  );
endinterface

// File: rtl/main_control_fsm_mem_wait_timer.sv
// mem_wait_timer
//   Counts consecutive not-ready cycles in a memory-wait state and flags a
//   timeout on the last tolerated cycle.
//   Ports: clk, reset (sync, active-high), waiting (in a wait state with
//   mem_ready=0), state_change (FSM leaves its current state this edge),
//   timeout (combinational: this not-ready cycle exhausts the budget).
//   MEM_TIMEOUT = 0 disables the timeout.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic state_change,
  output logic timeout
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT =
    CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (state_change) begin
      count_next = '0;
    end else if (waiting) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // waiting is already false when mem_ready=1, so a completing handshake
  // always wins over the timeout in the same cycle.
  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      assign timeout = waiting && (count_reg == LAST_WAIT);
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm
//   Multi-cycle main control unit: sequences each instruction through
//   fetch/decode/execute/memory/writeback, drives the ALU operation class
//   and datapath enables, stalls on mem_ready and halts on illegal opcodes
//   or memory timeouts (sticky illegal / mem_err, cleared only by reset).
//   Ports: clk, reset (sync, active-high), ctrl (main_control_fsm_if.master).
//   Optional build macro MAIN_CTRL_DEBUG_EN adds state_dbg[3:0] (current
//   state) and instr_count[31:0] (retired instructions, wraps).
module main_control_fsm
  import main_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  main_control_fsm_if.master   ctrl
`ifdef MAIN_CTRL_DEBUG_EN
  ,
  output logic [3:0]           state_dbg,
  output logic [31:0]          instr_count
`endif
);

  state_t state_reg, state_next;
  logic   illegal_reg, illegal_next;
  logic   mem_err_reg, mem_err_next;
  logic   waiting, timeout, state_change, boundary;

  assign waiting      = is_mem_wait_state(state_reg) && !ctrl.mem_ready;
  assign state_change = (state_next != state_reg);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk          (clk),
    .reset        (reset),
    .waiting      (waiting),
    .state_change (state_change),
    .timeout      (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      illegal_reg <= 1'b0;
      mem_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
      mem_err_reg <= mem_err_next;
    end
  end

  // Next state
  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    mem_err_next = mem_err_reg;
    boundary     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ctrl.start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (ctrl.mem_ready) begin
          state_next = ST_DECODE;
        end else if (timeout) begin
          state_next   = ST_HALT;
          mem_err_next = 1'b1;
        end
      end
      ST_DECODE: begin
        case (ctrl.opcode)
          OPC_LOAD, OPC_STORE: state_next = ST_MEM_ADDR;
          OPC_RTYPE:           state_next = ST_EXEC_R;
          OPC_BRANCH:          state_next = ST_BRANCH;
          default: begin
            state_next   = ST_HALT;
            illegal_next = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        state_next = (ctrl.opcode == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        if (ctrl.mem_ready) begin
          state_next = ST_MEM_WB;
        end else if (timeout) begin
          state_next   = ST_HALT;
          mem_err_next = 1'b1;
        end
      end
      ST_MEM_WR: begin
        if (ctrl.mem_ready) begin
          boundary = 1'b1;
        end else if (timeout) begin
          state_next   = ST_HALT;
          mem_err_next = 1'b1;
        end
      end
      ST_EXEC_R:                    state_next = ST_R_WB;
      ST_MEM_WB, ST_R_WB, ST_BRANCH: boundary  = 1'b1;
      ST_HALT:                      state_next = ST_HALT;
      default:                      state_next = ST_IDLE;
    endcase
    // start is only honoured between instructions.
    if (boundary) state_next = ctrl.start ? ST_FETCH : ST_IDLE;
  end

  // Moore outputs; only IR_Write/PC_Write in FETCH are gated by mem_ready.
  logic [1:0] alu_op;
  logic [1:0] alu_src_b;
  logic       alu_src_a, iord, mem_read, mem_write, ir_write, pc_write;
  logic       pc_write_cond, pc_source, reg_write, mem_to_reg;

  always_comb begin
    alu_op        = ALU_OP_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ctrl.mem_ready;
        pc_write  = ctrl.mem_ready;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ST_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl.ALU_OpOut    = alu_op;
  assign ctrl.ALUSrcA      = alu_src_a;
  assign ctrl.ALUSrcB      = alu_src_b;
  assign ctrl.IorD         = iord;
  assign ctrl.MemRead      = mem_read;
  assign ctrl.MemWrite     = mem_write;
  assign ctrl.IR_Write     = ir_write;
  assign ctrl.PC_Write     = pc_write;
  assign ctrl.PC_WriteCond = pc_write_cond;
  assign ctrl.PCSource     = pc_source;
  assign ctrl.RegWrite     = reg_write;
  assign ctrl.MemtoReg     = mem_to_reg;
  assign ctrl.busy         = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
  assign ctrl.illegal      = illegal_reg;
  assign ctrl.mem_err      = mem_err_reg;

`ifdef MAIN_CTRL_DEBUG_EN
  logic [31:0] instr_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count_reg <= 32'd0;
    end else if (boundary) begin
      instr_count_reg <= instr_count_reg + 32'd1;
    end
  end

  assign state_dbg   = state_reg;
  assign instr_count = instr_count_reg;
`endif

endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm
//   Randomized bench for main_control_fsm. Each instruction is planned at
//   transaction level (opcode, fetch waits, memory waits, start at the
//   boundary) and the expected per-cycle control outputs are derived from
//   the per-phase output table of the control unit.
module tb_main_control_fsm;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b0010011;

  logic clk = 1'b0;
  logic reset;

  main_control_fsm_if ctrl_if ();

`ifdef MAIN_CTRL_DEBUG_EN
  logic [3:0]  state_dbg;
  logic [31:0] instr_count;
`endif

  main_control_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl_if)
`ifdef MAIN_CTRL_DEBUG_EN
    ,
    .state_dbg   (state_dbg),
    .instr_count (instr_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          m_illegal, m_mem_err, m_idle;
  int unsigned m_instr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // {ALU_OpOut, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IR_Write,
  //  PC_Write, PC_WriteCond, PCSource, RegWrite, MemtoReg, busy}
  function automatic logic [14:0] ov(input logic [1:0] aluop, input logic srca,
                                     input logic [1:0] srcb, input logic iord,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic pcw, input logic pcwc, input logic pcs,
                                     input logic rw, input logic m2r, input logic busy);
    return {aluop, srca, srcb, iord, mr, mw, irw, pcw, pcwc, pcs, rw, m2r, busy};
  endfunction

  function automatic logic [14:0] e_idle();     return 15'd0; endfunction
  function automatic logic [14:0] e_halt();     return 15'd0; endfunction
  function automatic logic [14:0] e_fetch(input logic rdy);
    return ov(2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, rdy, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic logic [14:0] e_decode();
    return ov(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic logic [14:0] e_mem_addr();
    return ov(2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic logic [14:0] e_mem_rd();
    return ov(2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic logic [14:0] e_mem_wb();
    return ov(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  endfunction
  function automatic logic [14:0] e_mem_wr();
    return ov(2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic logic [14:0] e_exec_r();
    return ov(2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic logic [14:0] e_r_wb();
    return ov(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endfunction
  function automatic logic [14:0] e_branch();
    return ov(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic logic [16:0] observe();
    return {ctrl_if.ALU_OpOut, ctrl_if.ALUSrcA, ctrl_if.ALUSrcB, ctrl_if.IorD,
            ctrl_if.MemRead, ctrl_if.MemWrite, ctrl_if.IR_Write, ctrl_if.PC_Write,
            ctrl_if.PC_WriteCond, ctrl_if.PCSource, ctrl_if.RegWrite, ctrl_if.MemtoReg,
            ctrl_if.busy, ctrl_if.illegal, ctrl_if.mem_err};
  endfunction

  // One clock cycle: drive inputs after the falling edge, check outputs 1ns later.
  task automatic step(input string tag, input logic st, input logic [6:0] opc,
                      input logic rdy, input logic [14:0] exp_core);
    @(negedge clk);
    ctrl_if.start     = st;
    ctrl_if.opcode    = opc;
    ctrl_if.mem_ready = rdy;
    #1;
    check(tag, {15'd0, observe()}, {15'd0, exp_core, m_illegal, m_mem_err});
`ifdef MAIN_CTRL_DEBUG_EN
    check("instr_count", instr_count, m_instr);
`endif
  endtask

  // Memory handshake phase: 'waits' not-ready cycles, then one ready cycle,
  // unless the wait budget runs out first.
  task automatic wait_phase(input string tag, input logic [6:0] opc, input int waits,
                            input logic [14:0] exp_wait, input logic [14:0] exp_done,
                            input logic st_done, output bit timed_out);
    timed_out = 1'b0;
    for (int i = 0; i < waits; i++) begin
      step(tag, rbit(), opc, 1'b0, exp_wait);
      if (MEM_TIMEOUT > 0 && i + 1 == MEM_TIMEOUT) begin
        timed_out = 1'b1;
        break;
      end
    end
    if (timed_out) m_mem_err = 1'b1;
    else step(tag, st_done, opc, 1'b1, exp_done);
  endtask

  task automatic do_instr(input logic [6:0] opc, input int fw, input int mw,
                          input logic st_end, output bit halted);
    bit to;
    halted = 1'b0;
    to     = 1'b0;
    if (m_idle) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        step("idle", 1'b0, 7'($urandom), rbit(), e_idle());
      step("idle_go", 1'b1, 7'($urandom), rbit(), e_idle());
      m_idle = 1'b0;
    end
    wait_phase("fetch", 7'($urandom), fw, e_fetch(1'b0), e_fetch(1'b1), rbit(), to);
    if (!to) begin
      step("decode", rbit(), opc, rbit(), e_decode());
      case (opc)
        OP_R: begin
          step("exec_r", rbit(), opc, rbit(), e_exec_r());
          step("r_wb", st_end, opc, rbit(), e_r_wb());
        end
        OP_BEQ: step("branch", st_end, opc, rbit(), e_branch());
        OP_LW: begin
          step("mem_addr", rbit(), opc, rbit(), e_mem_addr());
          wait_phase("mem_rd", opc, mw, e_mem_rd(), e_mem_rd(), rbit(), to);
          if (!to) step("mem_wb", st_end, opc, rbit(), e_mem_wb());
        end
        OP_SW: begin
          step("mem_addr", rbit(), opc, rbit(), e_mem_addr());
          wait_phase("mem_wr", opc, mw, e_mem_wr(), e_mem_wr(), st_end, to);
        end
        default: m_illegal = 1'b1;
      endcase
    end
    halted = to || m_illegal;
    if (halted) begin
      $display("instr opc=%b fw=%0d mw=%0d -> halt (illegal=%0d mem_err=%0d)",
               opc, fw, mw, m_illegal, m_mem_err);
    end else begin
      m_instr++;
      m_idle = !st_end;
      $display("instr opc=%b fw=%0d mw=%0d start_next=%0d retired=%0d",
               opc, fw, mw, st_end, m_instr);
    end
  endtask

  // Reset for one edge; outputs are checked in the cycle after it.
  task automatic do_reset(input logic rdy);
    @(negedge clk);
    reset             = 1'b1;
    ctrl_if.start     = 1'b1;
    ctrl_if.mem_ready = rdy;
    @(negedge clk);
    reset         = 1'b0;
    ctrl_if.start = 1'b0;
    m_illegal = 1'b0;
    m_mem_err = 1'b0;
    m_instr   = 0;
    m_idle    = 1'b1;
    #1;
    check("reset", {15'd0, observe()}, 32'd0);
`ifdef MAIN_CTRL_DEBUG_EN
    check("reset_instr_count", instr_count, 32'd0);
`endif
  endtask

  task automatic run(input logic [6:0] opc, input int fw, input int mw, input logic st_end);
    bit halted;
    do_instr(opc, fw, mw, st_end, halted);
    if (halted) begin
      for (int i = 0; i < 3; i++) step("halt", rbit(), 7'($urandom), rbit(), e_halt());
      do_reset(rbit());
    end
  endtask

  function automatic logic [6:0] pick_opcode();
    logic [6:0] o;
    case ($urandom_range(0, 11))
      0, 1, 2: o = OP_R;
      3, 4, 5: o = OP_LW;
      6, 7, 8: o = OP_SW;
      9, 10:   o = OP_BEQ;
      default: begin
        o = 7'($urandom);
        while (o == OP_R || o == OP_LW || o == OP_SW || o == OP_BEQ) o = 7'($urandom);
      end
    endcase
    return o;
  endfunction

  initial begin
    bit halted;
    reset             = 1'b1;
    ctrl_if.start     = 1'b0;
    ctrl_if.opcode    = 7'd0;
    ctrl_if.mem_ready = 1'b0;
    do_reset(1'b0);

    // Directed: basic instruction flows and cycle counts.
    run(OP_R,   0, 0, 1'b1);
    run(OP_LW,  0, 3, 1'b1);
    run(OP_BEQ, 0, 0, 1'b1);
    run(OP_SW,  0, 0, 1'b0);
    // Ready on the last tolerated wait cycle: no error.
    run(OP_R,  MEM_TIMEOUT - 1, 0, 1'b1);
    run(OP_SW, 1, MEM_TIMEOUT - 1, 1'b1);
    // Timeouts in FETCH and MEM_RD, then an illegal opcode.
    run(OP_R,  MEM_TIMEOUT + 3, 0, 1'b1);
    run(OP_LW, 0, MEM_TIMEOUT, 1'b1);
    run(OP_BAD, 0, 0, 1'b1);

    // Reset while waiting in MEM_WR, with mem_ready high on the reset edge.
    do_instr(OP_R, 0, 0, 1'b1, halted);
    step("fetch", 1'b1, 7'($urandom), 1'b1, e_fetch(1'b1));
    step("decode", 1'b1, OP_SW, 1'b0, e_decode());
    step("mem_addr", 1'b1, OP_SW, 1'b0, e_mem_addr());
    step("mem_wr", 1'b1, OP_SW, 1'b0, e_mem_wr());
    do_reset(1'b1);

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      int fw, mw;
      fw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(MEM_TIMEOUT - 1, MEM_TIMEOUT + 2))
                                        : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(MEM_TIMEOUT - 1, MEM_TIMEOUT + 2))
                                        : int'($urandom_range(0, 3));
      run(pick_opcode(), fw, mw, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
